// File: rtl/calc_display_scan.sv
// Multiplexed 7-segment scan driver for the calculator result. It latches a number
// and shows it one digit per scan period, with blanking, decimal point, sign and error glyph.
module calc_display_scan #(
   parameter int unsigned ScanDiv   = 1000,
   parameter int unsigned NumDigits = 8,
   localparam int unsigned DigW     = $clog2(NumDigits),
   localparam int unsigned ExpW     = DigW,
   localparam int unsigned SigW     = 4 * NumDigits,
   localparam int unsigned NumW     = 2 + ExpW + SigW,
   localparam int unsigned DivW     = (ScanDiv > 1) ? $clog2(ScanDiv) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NumW-1:0]      num_i,
   input  logic                 load_i,
   input  logic                 enable_i,
   output logic [NumDigits-1:0] digit_sel_o,
   output logic [6:0]           segments_o,
   output logic                 dp_o,
   output logic                 sign_o,
   output logic                 frame_o
);

   logic [DivW-1:0] div_q;
   logic [DigW-1:0] digit_q;
   logic [NumW-1:0] disp_q;
   logic [NumW-1:0] shadow_q;
   logic            pend_q;
   logic            wrap_q;
   logic            tick;
   logic            commit;

   function automatic logic [6:0] bcd2segments(input logic [3:0] bcd);
      case (bcd)
         4'd0:    return 7'b1111110;
         4'd1:    return 7'b0110000;
         4'd2:    return 7'b1101101;
         4'd3:    return 7'b1111001;
         4'd4:    return 7'b0110011;
         4'd5:    return 7'b1011011;
         4'd6:    return 7'b1011111;
         4'd7:    return 7'b1110000;
         4'd8:    return 7'b1111111;
         default: return 7'b1111011;
      endcase
   endfunction

   assign tick   = (div_q == DivW'(ScanDiv - 1));
   assign commit = tick && (digit_q == DigW'(NumDigits - 1));

   // Stage p0: divider, digit counter, load shadow and tear-free commit at frame end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q    <= '0;
         digit_q  <= '0;
         disp_q   <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         if (tick) begin
            div_q   <= '0;
            digit_q <= (digit_q == DigW'(NumDigits - 1)) ? '0 : digit_q + DigW'(1);
         end else begin
            div_q <= div_q + DivW'(1);
         end
         wrap_q <= commit;
         if (commit) begin
            disp_q <= load_i ? num_i : (pend_q ? shadow_q : disp_q);
            pend_q <= 1'b0;
         end else if (load_i) begin
            pend_q <= 1'b1;
         end
         if (load_i) shadow_q <= num_i;
      end
   end

   logic                 sign_w;
   logic                 err_w;
   logic [ExpW-1:0]      exp_w;
   logic [SigW-1:0]      sig_w;
   logic [SigW-1:0]      upper_w;
   logic [NumDigits-1:0] sel_p0;
   logic [6:0]           seg_p0;
   logic                 dp_p0;
   logic                 sign_p0;

   assign {sign_w, err_w, exp_w, sig_w} = disp_q;
   // upper_w holds the current digit and everything left of it; zero means a leading zero
   assign upper_w = sig_w >> {digit_q, 2'b00};

   always_comb begin
      sel_p0  = '0;
      seg_p0  = '0;
      dp_p0   = 1'b0;
      sign_p0 = 1'b0;
      if (enable_i) begin
         sel_p0 = NumDigits'(1) << digit_q;
         if (err_w) begin
            seg_p0 = (digit_q == '0) ? 7'b1001111 : 7'b0000000;
         end else begin
            seg_p0  = ((digit_q > exp_w) && (upper_w == '0)) ? 7'b0000000
                                                             : bcd2segments(upper_w[3:0]);
            dp_p0   = (digit_q == exp_w);
            sign_p0 = sign_w && (sig_w != '0);
         end
      end
   end

   // Stage p1: registered pin outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digit_sel_o <= '0;
         segments_o  <= '0;
         dp_o        <= 1'b0;
         sign_o      <= 1'b0;
         frame_o     <= 1'b0;
      end else begin
         digit_sel_o <= sel_p0;
         segments_o  <= seg_p0;
         dp_o        <= dp_p0;
         sign_o      <= sign_p0;
         frame_o     <= wrap_q;
      end
   end

endmodule

// File: tb/tb_calc_display_scan.sv
// Self-checking bench for calc_display_scan: directed scenarios plus random traffic,
// all checked against a cycle-count based reference model.
module tb_calc_display_scan;
   localparam int SD    = 2;
   localparam int ND    = 8;
   localparam int FRAME = SD * ND;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        load  = 1'b0;
   logic        en    = 1'b1;
   logic [36:0] num   = '0;
   logic [7:0]  sel;
   logic [6:0]  seg;
   logic        dp;
   logic        sgn;
   logic        frame;

   int nt = 0;
   int nf = 0;

   calc_display_scan #(.ScanDiv(SD), .NumDigits(ND)) dut (
      .clk_i(clk), .rst_ni(rst_n), .num_i(num), .load_i(load), .enable_i(en),
      .digit_sel_o(sel), .segments_o(seg), .dp_o(dp), .sign_o(sgn), .frame_o(frame)
   );

   always #5 clk = ~clk;

   function automatic logic [36:0] mk(input logic s, input logic e, input logic [2:0] x,
                                      input logic [31:0] g);
      return {s, e, x, g};
   endfunction

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         default: return 7'b1111011;
      endcase
   endfunction

   // Expected {sel, seg, dp, sign} when digit i of number n is on screen
   function automatic logic [16:0] view(input logic [36:0] n, input int i, input logic on);
      longint unsigned s     = n[31:0];
      int              e     = int'(n[34:32]);
      longint unsigned scale = 64'd1 << (4 * i);
      int              dig   = int'((s / scale) % 16);
      logic [7:0]      vsel  = 8'(1 << i);
      logic [6:0]      vseg;
      logic            vdp;
      logic            vsg;
      if (!on) return '0;
      if (n[35]) begin
         vseg = (i == 0) ? 7'b1001111 : 7'd0;
         vdp  = 1'b0;
         vsg  = 1'b0;
      end else begin
         vseg = (i > e && (s / scale) == 0) ? 7'd0 : glyph(dig);
         vdp  = (i == e);
         vsg  = n[36] && (s != 0);
      end
      return {vsel, vseg, vdp, vsg};
   endfunction

   // Reference model: position in the scan follows from the number of edges since reset
   int unsigned k_m;
   logic [36:0] disp_m;
   logic [36:0] shadow_m;
   logic        pend_m;
   logic [16:0] out_m;
   logic        frame_m;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_m <= 0; disp_m <= '0; shadow_m <= '0; pend_m <= 1'b0; out_m <= '0; frame_m <= 1'b0;
      end else begin
         int unsigned kn;
         kn = k_m + 1;
         k_m     <= kn;
         out_m   <= view(disp_m, int'(((kn - 1) / SD) % ND), en);
         frame_m <= (kn > 1) && ((kn - 1) % FRAME == 0);
         if (kn % FRAME == 0) begin
            disp_m <= load ? num : (pend_m ? shadow_m : disp_m);
            pend_m <= 1'b0;
         end else if (load) begin
            pend_m <= 1'b1;
         end
         if (load) shadow_m <= num;
      end
   end

   function automatic logic [36:0] rnd_num();
      logic [31:0] s  = '0;
      int          nd = $urandom_range(0, 8);
      for (int i = 0; i < nd; i++)
         s[4*i +: 4] = ($urandom % 16 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      return {1'($urandom), 1'($urandom % 8 == 0), 3'($urandom), s};
   endfunction

   task automatic load_num(input logic [36:0] n);
      num = n; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_frame();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (frame !== 1'b1 && t < 4 * FRAME);
      nt++;
      if (frame !== 1'b1) begin
         nf++;
         $display("FAIL frame_timeout: frame_o=%b after %0d cycles, required 1", frame, t);
      end
   endtask

   task automatic test_reset();
      int d;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      nt++;
      if ({sel, seg, dp, sgn, frame} !== 18'd0) begin
         nf++;
         $display("FAIL reset_outputs: got %b, required all zero", {sel, seg, dp, sgn, frame});
      end
      rst_n = 1'b1;
      @(negedge clk);
      nt++;
      if (sel !== 8'h01 || seg !== 7'b1111110 || dp !== 1'b1 || sgn !== 1'b0 || frame !== 1'b0) begin
         nf++;
         $display("FAIL first_cycle: sel=%h seg=%b dp=%b sign=%b frame=%b, required 01 1111110 1 0 0",
                  sel, seg, dp, sgn, frame);
      end
      for (int j = 1; j < 2 * FRAME; j++) begin
         @(negedge clk);
         d = (j / SD) % ND;
         nt++;
         if (sel !== 8'(1 << d) || frame !== (j % FRAME == 0) || {sel, seg, dp, sgn} !== out_m) begin
            nf++;
            $display("FAIL idle_scan_%0d: sel=%h frame=%b out=%b, required sel=%h frame=%b out=%b",
                     j, sel, frame, {sel, seg, dp, sgn}, 8'(1 << d), (j % FRAME == 0), out_m);
         end
         if (d != 0) begin
            nt++;
            if (seg !== 7'd0) begin
               nf++;
               $display("FAIL idle_blank_d%0d: seg=%b, required 0000000", d, seg);
            end
         end
      end
   endtask

   task automatic test_number();
      logic [6:0] tbl [8] = '{7'b1011011, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000,
                              7'd0, 7'd0, 7'd0};
      int d;
      load_num(mk(1'b0, 1'b0, 3'd2, 32'h00012345));
      wait_frame();
      for (int j = 0; j < FRAME; j++) begin
         d = j / SD;
         nt++;
         if (sel !== 8'(1 << d) || seg !== tbl[d] || dp !== (d == 2) || sgn !== 1'b0 ||
             {sel, seg, dp, sgn} !== out_m) begin
            nf++;
            $display("FAIL number_d%0d: sel=%h seg=%b dp=%b sign=%b, required sel=%h seg=%b dp=%b sign=0",
                     d, sel, seg, dp, sgn, 8'(1 << d), tbl[d], (d == 2));
         end
         if (j < FRAME - 1) @(negedge clk);
      end
   endtask

   task automatic test_sign();
      int d;
      logic [6:0] es;
      load_num(mk(1'b1, 1'b0, 3'd1, 32'd5));
      wait_frame();
      for (int j = 0; j < FRAME; j++) begin
         d  = j / SD;
         es = (d == 0) ? 7'b1011011 : ((d == 1) ? 7'b1111110 : 7'd0);
         nt++;
         if (seg !== es || dp !== (d == 1) || sgn !== 1'b1 || {sel, seg, dp, sgn} !== out_m) begin
            nf++;
            $display("FAIL neg_five_d%0d: seg=%b dp=%b sign=%b, required seg=%b dp=%b sign=1",
                     d, seg, dp, sgn, es, (d == 1));
         end
         if (j < FRAME - 1) @(negedge clk);
      end
      load_num(mk(1'b1, 1'b0, 3'd0, 32'd0));
      wait_frame();
      for (int j = 0; j < FRAME; j++) begin
         d  = j / SD;
         es = (d == 0) ? 7'b1111110 : 7'd0;
         nt++;
         if (seg !== es || dp !== (d == 0) || sgn !== 1'b0 || {sel, seg, dp, sgn} !== out_m) begin
            nf++;
            $display("FAIL neg_zero_d%0d: seg=%b dp=%b sign=%b, required seg=%b dp=%b sign=0",
                     d, seg, dp, sgn, es, (d == 0));
         end
         if (j < FRAME - 1) @(negedge clk);
      end
   endtask

   task automatic test_error();
      int d;
      logic [6:0] es;
      load_num(mk(1'b1, 1'b1, 3'd3, 32'h12345678));
      wait_frame();
      for (int j = 0; j < FRAME; j++) begin
         d  = j / SD;
         es = (d == 0) ? 7'b1001111 : 7'd0;
         nt++;
         if (sel !== 8'(1 << d) || seg !== es || dp !== 1'b0 || sgn !== 1'b0 ||
             {sel, seg, dp, sgn} !== out_m) begin
            nf++;
            $display("FAIL error_d%0d: sel=%h seg=%b dp=%b sign=%b, required sel=%h seg=%b dp=0 sign=0",
                     d, sel, seg, dp, sgn, 8'(1 << d), es);
         end
         if (j < FRAME - 1) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int d;
      logic [6:0] es;
      load_num(mk(1'b0, 1'b0, 3'd0, 32'h88888888));
      wait_frame();
      wait_frame();
      repeat (6) @(negedge clk);
      load_num(mk(1'b0, 1'b0, 3'd0, 32'd1));
      load_num(mk(1'b0, 1'b0, 3'd0, 32'd2));
      // Rest of the current frame still shows the old eights
      for (int j = 8; j < FRAME; j++) begin
         nt++;
         if (seg !== 7'b1111111 || {sel, seg, dp, sgn} !== out_m) begin
            nf++;
            $display("FAIL midframe_hold_%0d: seg=%b out=%b, required seg=1111111 out=%b",
                     j, seg, {sel, seg, dp, sgn}, out_m);
         end
         if (j < FRAME - 1) @(negedge clk);
      end
      wait_frame();
      for (int j = 0; j < FRAME; j++) begin
         d  = j / SD;
         es = (d == 0) ? 7'b1101101 : 7'd0;
         nt++;
         if (seg !== es || {sel, seg, dp, sgn} !== out_m) begin
            nf++;
            $display("FAIL last_load_wins_d%0d: seg=%b, required %b", d, seg, es);
         end
         if (j == FRAME - 2) begin
            num = mk(1'b0, 1'b0, 3'd0, 32'd7); load = 1'b1;
         end
         if (j == FRAME - 1) load = 1'b0;
         @(negedge clk);
      end
      load = 1'b0;
      nt++;
      if (frame !== 1'b1 || sel !== 8'h01 || seg !== 7'b1110000) begin
         nf++;
         $display("FAIL commit_cycle_load: frame=%b sel=%h seg=%b, required 1 01 1110000", frame, sel, seg);
      end
      // Load one cycle after the commit waits for the following frame
      load_num(mk(1'b0, 1'b0, 3'd0, 32'd3));
      for (int j = 1; j < FRAME; j++) begin
         d  = j / SD;
         es = (d == 0) ? 7'b1110000 : 7'd0;
         nt++;
         if (seg !== es || {sel, seg, dp, sgn} !== out_m) begin
            nf++;
            $display("FAIL post_commit_hold_%0d: seg=%b, required %b", j, seg, es);
         end
         if (j < FRAME - 1) @(negedge clk);
      end
      wait_frame();
      nt++;
      if (seg !== 7'b1111001 || {sel, seg, dp, sgn} !== out_m) begin
         nf++;
         $display("FAIL post_commit_next: seg=%b, required 1111001", seg);
      end
   endtask

   task automatic test_enable();
      int pulses = 0;
      en = 1'b0;
      for (int j = 0; j < 2 * FRAME; j++) begin
         @(negedge clk);
         if (frame === 1'b1) pulses++;
         nt++;
         if ({sel, seg, dp, sgn} !== 17'd0 || frame !== frame_m) begin
            nf++;
            $display("FAIL disabled_%0d: out=%b frame=%b, required out=0 frame=%b",
                     j, {sel, seg, dp, sgn}, frame, frame_m);
         end
      end
      nt++;
      if (pulses != 2) begin
         nf++;
         $display("FAIL disabled_pulses: got %0d frame pulses in %0d cycles, required 2", pulses, 2 * FRAME);
      end
      en = 1'b1;
      @(negedge clk);
      nt++;
      if (sel === 8'd0 || {sel, seg, dp, sgn} !== out_m) begin
         nf++;
         $display("FAIL reenable: out=%b, required %b", {sel, seg, dp, sgn}, out_m);
      end
   endtask

   task automatic test_reset_mid();
      int d;
      logic [6:0] es;
      wait_frame();
      repeat (4) @(negedge clk);
      load_num(mk(1'b0, 1'b0, 3'd0, 32'd9));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      nt++;
      if ({sel, seg, dp, sgn, frame} !== 18'd0) begin
         nf++;
         $display("FAIL async_reset: got %b, required all zero", {sel, seg, dp, sgn, frame});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 2 * FRAME; j++) begin
         @(negedge clk);
         d  = (j / SD) % ND;
         es = (d == 0) ? 7'b1111110 : 7'd0;
         nt++;
         if (seg !== es || frame !== (j > 0 && j % FRAME == 0) || {sel, seg, dp, sgn} !== out_m) begin
            nf++;
            $display("FAIL after_reset_%0d: seg=%b frame=%b, required seg=%b frame=%b",
                     j, seg, frame, es, (j > 0 && j % FRAME == 0));
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         load = ($urandom % 6 == 0);
         if (load) num = rnd_num();
         en = ($urandom % 8 != 0);
         @(negedge clk);
         nt++;
         if ({sel, seg, dp, sgn, frame} !== {out_m, frame_m}) begin
            nf++;
            $display("FAIL random_%0d: out=%b frame=%b, required out=%b frame=%b",
                     c, {sel, seg, dp, sgn}, frame, out_m, frame_m);
         end
      end
      load = 1'b0;
      en   = 1'b1;
   endtask

   initial begin
      #1;
      test_reset();
      test_number();
      test_sign();
      test_error();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nt, nf);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
